// File: rtl/encoder4_2_seq_if.sv
// Request/code bus of the sequential 4-to-2 priority encoder.
// Handshake: the encoder holds `out` stable while `valid`=1; a code is
// transferred on the rising edge where `valid` and `ready` are both 1.
// `ready` may be asserted at any time and has no effect while `valid`=0.
interface encoder4_2_seq_if;
   logic       en;
   logic [3:0] in;
   logic [1:0] out;
   logic       valid;
   logic       ready;
   logic       empty;

   // Environment side: drives requests and consumes codes
   modport master (
      output en, in, ready,
      input  out, valid, empty
   );

   // Encoder side
   modport slave (
      input  en, in, ready,
      output out, valid, empty
   );
endinterface

// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 priority encoder: request lines are merged into a pending
// register and emitted one code per handshake, highest index first.
module encoder4_2_seq (
   input  logic                   clk,
   input  logic                   rst,
   encoder4_2_seq_if.slave        bus,
   output logic                   dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t     state_q;
   logic [3:0] pend_q;
   logic [3:0] pend_d;
   logic [1:0] out_q;
   logic       valid_q;
   logic [1:0] enc;
   logic [3:0] clr;
   logic       load;

   // Priority encode of the registered pending bits; highest index wins
   always_comb begin
      enc = 2'b00;
      if (pend_q[3])      enc = 2'b11;
      else if (pend_q[2]) enc = 2'b10;
      else if (pend_q[1]) enc = 2'b01;
      else                enc = 2'b00;
   end

   // Load decision, one-hot clear of the loaded bit and next pending value;
   // new captures are ORed in after the clear so a set beats a clear
   always_comb begin
      load   = (pend_q != 4'b0000) &&
               ((state_q == IDLE) || ((state_q == HOLD) && bus.ready));
      clr    = load ? (4'b0001 << enc) : 4'b0000;
      pend_d = (pend_q & ~clr) | (bus.en ? bus.in : 4'b0000);
   end

   // FSM with registered code/valid outputs and the pending register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= 4'b0000;
         out_q   <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         case (state_q)
            IDLE: begin
               if (load) begin
                  out_q   <= enc;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (bus.ready) begin
                  if (load) begin
                     out_q <= enc;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out     = out_q;
   assign bus.valid   = valid_q;
   assign bus.empty   = (pend_q == 4'b0000) && !valid_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/encoder4_2_seq.md
# encoder4_2_seq

Sequential 4-to-2 priority encoder: the inverse of the 2-to-4 decoder. Captures one-hot or multi-hot request lines into a pending register and emits each pending request, one per handshake, as a 2-bit binary code with a valid/ready handshake. Sits between request sources (for example, a decoder's one-hot outputs or independent event lines) and a consumer that accepts one code at a time.

## Interface
- No parameters; the width is fixed at 4 request lines and a 2-bit code.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; 0 means `in` is ignored.
- in  input  [3:0]  request lines, sampled every edge when `en`=1.
- out  output  [1:0]  encoded index of the presented request.
- valid  output  1  `out` holds a request.
- ready  input  1  the consumer accepts `out` this edge when `valid`=1.
- empty  output  1  high when there is no pending request and `valid`=0.

## Operation
- Pending register `P[3:0]`:
  - Each edge, `P` takes `(P & ~clr) | (en ? in : 4'b0000)`.
  - `clr` is the one-hot bit selected for loading on that edge; otherwise it is 0.
  - Set wins over clear when both hit the same bit on the same edge.
- Encoding is a priority scheme; the highest index wins:
  - `P[3]` gives 2'b11.
  - else `P[2]` gives 2'b10.
  - else `P[1]` gives 2'b01.
  - else `P[0]` gives 2'b00.
  - This is the exact inverse of the decoder mapping (2'b00 maps to 4'b0001 … 2'b11 maps to 4'b1000).
- Selection uses the registered `P` only. Arrivals on the current edge are not eligible until the next cycle.
- FSM states:
  - IDLE (`valid`=0):
    - If `P`≠0, load `out`=enc(`P`), clear that bit, and go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD (`valid`=1), `out` held stable until the handshake:
    - If `ready`=1 and `P`≠0, load the next `out`=enc(`P`), clear that bit, and stay in HOLD. This gives back-to-back transfers.
    - If `ready`=1 and `P`=0, go to IDLE with `valid`=0. `out` keeps its last value.
    - If `ready`=0, hold `out` and `valid`.
- Duplicate requests:
  - A request on a bit already pending merges; there is no count.
  - A request on the bit currently presented on `out` re-sets `P` and is emitted again later.
- `en`=0 only blocks capture. Draining of `P` and the handshake continue.
- `empty` is combinational: (`P`==0) && !`valid`.

## Timing
- Reset (`rst`=1 at an edge):
  - `P`=4'b0000, `out`=2'b00, `valid`=0, state IDLE. `empty`=1 after that edge.
  - `rst` overrides `en`, `in` and `ready` on the same edge.
  - Reset mid-transfer discards all pending and presented requests.
- Latency: a request sampled at edge N gives `valid`=1 with its code after edge N+1, if the block is idle and no higher-priority request is pending.
- Throughput: one code per cycle while `ready`=1 and `P`≠0.
- `out` and `valid` are registered. `out` changes only on load edges.
- Starvation of low-index requests under a constant high-index stream is accepted behaviour.

## Test plan
- Reset, then `en`=1, `in`=4'b0100 for one cycle, `ready`=1:
  - `valid`=1 and `out`=2'b10 after the second edge.
  - `valid`=0 and `empty`=1 after the next edge.
- `in`=4'b1011 for one cycle, `ready`=1:
  - Three consecutive valid cycles with `out`=2'b11, 2'b01, 2'b00.
  - Then `valid`=0.
- `in`=4'b0001 with `ready`=0 held for 5 cycles:
  - `out`=2'b00 and `valid`=1 stay stable.
  - Raising `ready` gives one transfer, then IDLE.
- While `out`=2'b01 is presented, pulse `in`=4'b0010 and then handshake:
  - 2'b01 is emitted a second time.
- `en`=0 with `in`=4'b1111:
  - `P` stays 0, `valid` stays 0, `empty`=1.
- Load `in`=4'b1110 and assert `rst` while `valid`=1:
  - After the edge, `valid`=0, `out`=2'b00, `empty`=1.
  - No stale codes are emitted afterwards.
